// File: rtl/lob_volume_query.sv
// Order-book volume query: scans one side of the book and sums the volume of matching entries.
// Build option LOB_QUERY_SATURATE_EN clamps the volume sum instead of letting it wrap.
module lob_volume_query #(
    parameter int PRICE_W = 16,
    parameter int VOL_W   = 16,
    parameter int ENTRY_W = 48,
    parameter int DEPTH   = 4096,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 13,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               side,
    input  logic               mode,
    input  logic [PRICE_W-1:0] limit,
    output logic               rd_en,
    output logic               rd_side,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [ENTRY_W-1:0] rd_data,
    output logic [ACC_W-1:0]   volume,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EVAL,
        DONE
    } state_t;

    state_t             state;
    logic               side_q;
    logic               mode_q;
    logic [PRICE_W-1:0] limit_q;
    logic [ADDR_W-1:0]  idx;

    logic [PRICE_W-1:0] ent_price;
    logic [VOL_W-1:0]   ent_vol;
    logic               ent_empty;
    logic               hit;
    logic               last;
    logic [ACC_W-1:0]   acc_next;

    assign ent_price = rd_data[PRICE_W-1:0];
    assign ent_vol   = rd_data[PRICE_W+VOL_W-1:PRICE_W];
    assign ent_empty = (rd_data == '0);
    assign last      = (idx == ADDR_W'(DEPTH - 1));

`ifdef LOB_QUERY_SATURATE_EN
    logic [ACC_W:0] sum;
    assign sum      = {1'b0, volume} + (ACC_W + 1)'(ent_vol);
    // once clamped, every later add overflows again, so the clamp sticks
    assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    logic [ACC_W-1:0] sum;
    assign sum      = volume + ACC_W'(ent_vol);
    assign acc_next = sum;
`endif

    always_comb begin
        hit = 1'b0;
        unique case (1'b1)
            !mode_q:           hit = (ent_price == limit_q);
            mode_q && !side_q: hit = (ent_price >= limit_q);
            default:           hit = (ent_price <= limit_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            side_q      <= 1'b0;
            mode_q      <= 1'b0;
            limit_q     <= '0;
            idx         <= '0;
            volume      <= '0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_side     <= 1'b0;
            rd_addr     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        side_q      <= side;
                        mode_q      <= mode;
                        limit_q     <= limit;
                        volume      <= '0;
                        match_count <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        rd_en       <= 1'b1;
                        rd_side     <= side;
                        rd_addr     <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (ent_empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (hit) begin
                            volume      <= acc_next;
                            match_count <= match_count + CNT_W'(1);
                        end
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx     <= idx + ADDR_W'(1);
                            rd_addr <= idx + ADDR_W'(1);
                            rd_en   <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    // start must drop before another query can begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lob_volume_query.sv
// Bench for lob_volume_query: directed book vectors, reset/hold sequences
// and randomized books against a scan-and-sum reference.
module tb_lob_volume_query;

    localparam int PRICE_W = 16;
    localparam int VOL_W   = 16;
    localparam int ENTRY_W = 48;
    localparam int DEPTH   = 8;
    localparam int ACC_W   = 8;
    localparam int CNT_W   = 4;
    localparam int ADDR_W  = 3;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

`ifdef LOB_QUERY_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic               side_i;
    logic               mode_i;
    logic [PRICE_W-1:0] limit_i;
    logic               rd_en;
    logic               rd_side;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ENTRY_W-1:0] rd_data;
    logic [ACC_W-1:0]   volume;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    lob_volume_query #(
        .PRICE_W(PRICE_W),
        .VOL_W  (VOL_W),
        .ENTRY_W(ENTRY_W),
        .DEPTH  (DEPTH),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .side       (side_i),
        .mode       (mode_i),
        .limit      (limit_i),
        .rd_en      (rd_en),
        .rd_side    (rd_side),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .volume     (volume),
        .match_count(match_count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ENTRY_W-1:0] mem [2][DEPTH];
    int                 log_addr [$];
    bit                 log_side [$];

    initial rd_data = '0;
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[int'(rd_side)][rd_addr];
    end

    always @(negedge clk) begin
        if (rd_en) begin
            log_addr.push_back(int'(rd_addr));
            log_side.push_back(rd_side);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input int price, input int vol);
        logic [ENTRY_W-1:0] w;
        w = '0;
        w[PRICE_W-1:0] = PRICE_W'(price);
        w[PRICE_W+VOL_W-1:PRICE_W] = VOL_W'(vol);
        return w;
    endfunction

    task automatic load_book(input int id, input bit s);
        for (int i = 0; i < DEPTH; i++) begin
            mem[int'(s)][i]  = '0;
            mem[int'(!s)][i] = ent(100, 50);
        end
        case (id)
            0: begin
                mem[int'(s)][0] = ent(100, 5);
                mem[int'(s)][1] = ent(101, 7);
                mem[int'(s)][2] = ent(100, 3);
            end
            1: begin
                mem[int'(s)][0] = ent(99, 4);
                mem[int'(s)][1] = ent(100, 6);
                mem[int'(s)][2] = ent(102, 1);
            end
            2: begin
                for (int i = 0; i < DEPTH; i++) mem[int'(s)][i] = ent(50, 2);
            end
            default: begin
                mem[int'(s)][0] = ent(150, 200);
                mem[int'(s)][1] = ent(160, 200);
            end
        endcase
    endtask

    // Reference: walk the book, stop at the first empty word or the end.
    task automatic model(input bit s, input bit m, input int lim,
                         output int vol, output int cnt, output int reads);
        int p;
        int v;
        bit hit;
        vol = 0;
        cnt = 0;
        reads = 0;
        for (int i = 0; i < DEPTH; i++) begin
            reads++;
            if (mem[int'(s)][i] == '0) break;
            p = int'(mem[int'(s)][i][PRICE_W-1:0]);
            v = int'(mem[int'(s)][i][PRICE_W+VOL_W-1:PRICE_W]);
            if (!m) hit = (p == lim);
            else if (!s) hit = (p >= lim);
            else hit = (p <= lim);
            if (hit) begin
                cnt++;
                vol = vol + v;
                if (SAT) vol = (vol > ACC_MAX) ? ACC_MAX : vol;
                else vol = vol % (ACC_MAX + 1);
            end
        end
    endtask

    task automatic run_query(input bit s, input bit m, input int lim, input int hold,
                             output int vol, output int cnt, output int nreads,
                             output bit seq_ok);
        int t;
        int n0;
        bit hold_ok;
        @(negedge clk);
        log_addr.delete();
        log_side.delete();
        side_i  = s;
        mode_i  = m;
        limit_i = PRICE_W'(lim);
        start   = 1'b1;
        @(negedge clk);
        check("busy_rise", busy, 1);
        side_i  = ~s;
        mode_i  = ~m;
        limit_i = PRICE_W'($urandom);
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        vol = int'(volume);
        cnt = int'(match_count);
        if (hold > 0) begin
            n0 = log_addr.size();
            hold_ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!done) hold_ok = 1'b0;
            end
            check("hold_done_high", hold_ok, 1);
            check("hold_no_read", log_addr.size(), n0);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_fall", done, 0);
        check("vol_retained", volume, vol);
        check("cnt_retained", match_count, cnt);
        nreads = log_addr.size();
        seq_ok = 1'b1;
        foreach (log_addr[i]) begin
            if (log_addr[i] != i || log_side[i] != s) seq_ok = 1'b0;
        end
    endtask

    typedef struct {
        bit s;
        bit m;
        int lim;
        int book;
        int e_vol;
        int e_cnt;
        int e_reads;
    } vec_t;

    vec_t vt[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vol;
        int cnt;
        int nr;
        bit ok;
        int e_vol;
        int e_cnt;
        int e_rd;
        int t;
        int cut;
        logic [15:0] up;

        vt[0] = '{s: 0, m: 0, lim: 100, book: 0, e_vol: 8,  e_cnt: 2, e_reads: 4};
        vt[1] = '{s: 0, m: 1, lim: 101, book: 0, e_vol: 7,  e_cnt: 1, e_reads: 4};
        vt[2] = '{s: 1, m: 1, lim: 100, book: 1, e_vol: 10, e_cnt: 2, e_reads: 4};
        vt[3] = '{s: 0, m: 0, lim: 50,  book: 2, e_vol: 16, e_cnt: 8, e_reads: 8};
        vt[4] = '{s: 0, m: 1, lim: 0,   book: 3, e_vol: SAT ? 255 : 144,
                  e_cnt: 2, e_reads: 3};
        vt[5] = '{s: 1, m: 1, lim: 49,  book: 2, e_vol: 0,  e_cnt: 0, e_reads: 8};

        rst = 1'b0;
        start = 1'b0;
        side_i = 1'b0;
        mode_i = 1'b0;
        limit_i = '0;
        #1;
        check("reset_outputs", {volume, match_count, busy, done, rd_en, rd_side, rd_addr}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vt[k]) begin
            load_book(vt[k].book, vt[k].s);
            run_query(vt[k].s, vt[k].m, vt[k].lim, 0, vol, cnt, nr, ok);
            check($sformatf("vec%0d_volume", k), vol, vt[k].e_vol);
            check($sformatf("vec%0d_count", k), cnt, vt[k].e_cnt);
            check($sformatf("vec%0d_reads", k), nr, vt[k].e_reads);
            check($sformatf("vec%0d_addr_seq", k), ok, 1);
        end

        // reset during WAIT of the second entry
        load_book(0, 0);
        @(negedge clk);
        log_addr.delete();
        log_side.delete();
        side_i = 1'b0;
        mode_i = 1'b0;
        limit_i = 16'd100;
        start = 1'b1;
        t = 0;
        while (!(rd_en && rd_addr == 3'd1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_entry2", rd_en && rd_addr == 3'd1, 1);
        @(negedge clk);
        check("pre_reset_volume", volume, 5);
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("midquery_reset", {volume, match_count, busy, done, rd_en, rd_side, rd_addr}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done, rd_en}, 0);
        run_query(0, 0, 101, 0, vol, cnt, nr, ok);
        check("post_reset_volume", vol, 7);
        check("post_reset_count", cnt, 1);

        // start held through DONE
        run_query(0, 0, 100, 10, vol, cnt, nr, ok);
        check("hold_volume", vol, 8);
        check("hold_reads", nr, 4);

        for (int it = 0; it < 30; it++) begin
            for (int sd = 0; sd < 2; sd++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    up = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0;
                    mem[sd][i] = {up,
                        ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40)),
                        16'($urandom_range(95, 105))};
                end
                cut = $urandom_range(0, DEPTH);
                if (cut < DEPTH) mem[sd][cut] = '0;
            end
            begin
                bit rs;
                bit rm;
                int rl;
                rs = 1'($urandom_range(0, 1));
                rm = 1'($urandom_range(0, 1));
                rl = $urandom_range(95, 105);
                model(rs, rm, rl, e_vol, e_cnt, e_rd);
                run_query(rs, rm, rl, 0, vol, cnt, nr, ok);
                check($sformatf("rnd%0d_volume", it), vol, e_vol);
                check($sformatf("rnd%0d_count", it), cnt, e_cnt);
                check($sformatf("rnd%0d_reads", it), nr, e_rd);
                check($sformatf("rnd%0d_addr_seq", it), ok, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
